// File: rtl/rs_alu.sv
// ALU/branch reservation station: buffers dispatched micro-ops, snoops the EX and
// LSB result broadcasts for missing operands, and issues the lowest ready entry.

module rs_alu_entry #(
  parameter int INS_OP_W  = 5,
  parameter int REG_DAT_W = 32,
  parameter int ROB_ADD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 iss,
  input  logic [INS_OP_W-1:0]  dp_op,
  input  logic [REG_DAT_W-1:0] dp_pc,
  input  logic [REG_DAT_W-1:0] dp_imm,
  input  logic                 dp_rdy1,
  input  logic [REG_DAT_W-1:0] dp_vs1,
  input  logic [ROB_ADD_W-1:0] dp_qs1,
  input  logic                 dp_rdy2,
  input  logic [REG_DAT_W-1:0] dp_vs2,
  input  logic [ROB_ADD_W-1:0] dp_qs2,
  input  logic [ROB_ADD_W-1:0] dp_qd,
  input  logic                 ex_en,
  input  logic [ROB_ADD_W-1:0] ex_qd,
  input  logic [REG_DAT_W-1:0] ex_vd,
  input  logic                 lsb_en,
  input  logic [ROB_ADD_W-1:0] lsb_qd,
  input  logic [REG_DAT_W-1:0] lsb_vd,
  output logic                 busy,
  output logic                 ready,
  output logic [INS_OP_W-1:0]  op,
  output logic [REG_DAT_W-1:0] pc,
  output logic [REG_DAT_W-1:0] imm,
  output logic [REG_DAT_W-1:0] vs1,
  output logic [REG_DAT_W-1:0] vs2,
  output logic [ROB_ADD_W-1:0] qd
);
  logic                 busy_q, busy_d;
  logic [INS_OP_W-1:0]  op_q, op_d;
  logic [REG_DAT_W-1:0] pc_q, pc_d, imm_q, imm_d;
  logic                 rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [REG_DAT_W-1:0] vs1_q, vs1_d, vs2_q, vs2_d;
  logic [ROB_ADD_W-1:0] qs1_q, qs1_d, qs2_q, qs2_d, qd_q, qd_d;

  // On a write the dispatched operand is what gets snooped, so the same-cycle
  // bypass and the resident-entry snoop share one path.
  logic                 watch;
  logic                 rin1, rin2;
  logic [REG_DAT_W-1:0] vin1, vin2;
  logic [ROB_ADD_W-1:0] qin1, qin2;

  always_comb begin
    watch = wr | busy_q;
    rin1  = wr ? dp_rdy1 : rdy1_q;
    vin1  = wr ? dp_vs1  : vs1_q;
    qin1  = wr ? dp_qs1  : qs1_q;
    rin2  = wr ? dp_rdy2 : rdy2_q;
    vin2  = wr ? dp_vs2  : vs2_q;
    qin2  = wr ? dp_qs2  : qs2_q;

    busy_d = busy_q;
    op_d   = wr ? dp_op  : op_q;
    pc_d   = wr ? dp_pc  : pc_q;
    imm_d  = wr ? dp_imm : imm_q;
    qd_d   = wr ? dp_qd  : qd_q;
    qs1_d  = qin1;
    qs2_d  = qin2;
    rdy1_d = rin1;
    vs1_d  = vin1;
    rdy2_d = rin2;
    vs2_d  = vin2;

    if (clr)      busy_d = 1'b0;
    else if (wr)  busy_d = 1'b1;
    else if (iss) busy_d = 1'b0;

    // EX broadcast takes precedence over LSB on a tag collision
    if (watch && !rin1) begin
      if (ex_en && ex_qd == qin1) begin
        rdy1_d = 1'b1;
        vs1_d  = ex_vd;
      end else if (lsb_en && lsb_qd == qin1) begin
        rdy1_d = 1'b1;
        vs1_d  = lsb_vd;
      end
    end
    if (watch && !rin2) begin
      if (ex_en && ex_qd == qin2) begin
        rdy2_d = 1'b1;
        vs2_d  = ex_vd;
      end else if (lsb_en && lsb_qd == qin2) begin
        rdy2_d = 1'b1;
        vs2_d  = lsb_vd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      op_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      rdy1_q <= 1'b0;
      vs1_q  <= '0;
      qs1_q  <= '0;
      rdy2_q <= 1'b0;
      vs2_q  <= '0;
      qs2_q  <= '0;
      qd_q   <= '0;
    end else if (upd) begin
      busy_q <= busy_d;
      op_q   <= op_d;
      pc_q   <= pc_d;
      imm_q  <= imm_d;
      rdy1_q <= rdy1_d;
      vs1_q  <= vs1_d;
      qs1_q  <= qs1_d;
      rdy2_q <= rdy2_d;
      vs2_q  <= vs2_d;
      qs2_q  <= qs2_d;
      qd_q   <= qd_d;
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q & rdy1_q & rdy2_q;
  assign op    = op_q;
  assign pc    = pc_q;
  assign imm   = imm_q;
  assign vs1   = vs1_q;
  assign vs2   = vs2_q;
  assign qd    = qd_q;
endmodule

module rs_alu #(
  parameter int RS_SIZE   = 8,
  parameter int RS_ADD_W  = 3,
  parameter int INS_OP_W  = 5,
  parameter int REG_DAT_W = 32,
  parameter int ROB_ADD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iROB_Clear,
  input  logic                 iDP_En,
  input  logic [INS_OP_W-1:0]  iDP_Op,
  input  logic [REG_DAT_W-1:0] iDP_Pc,
  input  logic [REG_DAT_W-1:0] iDP_Imm,
  input  logic                 iDP_Rdy1,
  input  logic [REG_DAT_W-1:0] iDP_Vs1,
  input  logic [ROB_ADD_W-1:0] iDP_Qs1,
  input  logic                 iDP_Rdy2,
  input  logic [REG_DAT_W-1:0] iDP_Vs2,
  input  logic [ROB_ADD_W-1:0] iDP_Qs2,
  input  logic [ROB_ADD_W-1:0] iDP_Qd,
  output logic                 oDP_Full,
  input  logic                 iEX_En,
  input  logic [ROB_ADD_W-1:0] iEX_Qd,
  input  logic [REG_DAT_W-1:0] iEX_Vd,
  input  logic                 iLSB_En,
  input  logic [ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [REG_DAT_W-1:0] iLSB_Vd,
  output logic                 oEX_En,
  output logic [INS_OP_W-1:0]  oEX_Op,
  output logic [REG_DAT_W-1:0] oEX_Pc,
  output logic [REG_DAT_W-1:0] oEX_Imm,
  output logic [REG_DAT_W-1:0] oEX_Vs1,
  output logic [REG_DAT_W-1:0] oEX_Vs2,
  output logic [ROB_ADD_W-1:0] oEX_Qd
);
  typedef struct packed {
    logic [INS_OP_W-1:0]  op;
    logic [REG_DAT_W-1:0] pc;
    logic [REG_DAT_W-1:0] imm;
    logic [REG_DAT_W-1:0] vs1;
    logic [REG_DAT_W-1:0] vs2;
    logic [ROB_ADD_W-1:0] qd;
  } iss_t;

  logic [RS_SIZE-1:0]                busy, ready, wr, iss;
  logic [RS_SIZE-1:0][INS_OP_W-1:0]  e_op;
  logic [RS_SIZE-1:0][REG_DAT_W-1:0] e_pc, e_imm, e_vs1, e_vs2;
  logic [RS_SIZE-1:0][ROB_ADD_W-1:0] e_qd;

  logic                upd, dp_go, iss_go;
  logic                free_any, sel_any;
  logic [RS_ADD_W-1:0] free_idx, sel_idx;

  // A clear acts even with en low; otherwise en gates every register.
  assign upd = en | iROB_Clear;

  // Both pickers look only at registered state, so a slot freed by issue
  // cannot be refilled at the same edge and new entries wait one cycle to issue.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    sel_any  = 1'b0;
    sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = RS_ADD_W'(i);
      end
      if (ready[i]) begin
        sel_any = 1'b1;
        sel_idx = RS_ADD_W'(i);
      end
    end
  end

  assign oDP_Full = &busy;
  assign dp_go    = en & ~iROB_Clear & iDP_En & free_any;
  assign iss_go   = en & ~iROB_Clear & sel_any;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign wr[g]  = dp_go  && (free_idx == RS_ADD_W'(g));
    assign iss[g] = iss_go && (sel_idx  == RS_ADD_W'(g));

    rs_alu_entry #(
      .INS_OP_W (INS_OP_W),
      .REG_DAT_W(REG_DAT_W),
      .ROB_ADD_W(ROB_ADD_W)
    ) u_ent (
      .clk    (clk),
      .rst    (rst),
      .upd    (upd),
      .clr    (iROB_Clear),
      .wr     (wr[g]),
      .iss    (iss[g]),
      .dp_op  (iDP_Op),
      .dp_pc  (iDP_Pc),
      .dp_imm (iDP_Imm),
      .dp_rdy1(iDP_Rdy1),
      .dp_vs1 (iDP_Vs1),
      .dp_qs1 (iDP_Qs1),
      .dp_rdy2(iDP_Rdy2),
      .dp_vs2 (iDP_Vs2),
      .dp_qs2 (iDP_Qs2),
      .dp_qd  (iDP_Qd),
      .ex_en  (iEX_En),
      .ex_qd  (iEX_Qd),
      .ex_vd  (iEX_Vd),
      .lsb_en (iLSB_En),
      .lsb_qd (iLSB_Qd),
      .lsb_vd (iLSB_Vd),
      .busy   (busy[g]),
      .ready  (ready[g]),
      .op     (e_op[g]),
      .pc     (e_pc[g]),
      .imm    (e_imm[g]),
      .vs1    (e_vs1[g]),
      .vs2    (e_vs2[g]),
      .qd     (e_qd[g])
    );
  end

  logic ex_en_q, ex_en_d;
  iss_t iss_q, iss_d;

  always_comb begin
    ex_en_d = iss_go;
    iss_d   = iss_q;
    if (iss_go) begin
      iss_d.op  = e_op[sel_idx];
      iss_d.pc  = e_pc[sel_idx];
      iss_d.imm = e_imm[sel_idx];
      iss_d.vs1 = e_vs1[sel_idx];
      iss_d.vs2 = e_vs2[sel_idx];
      iss_d.qd  = e_qd[sel_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_en_q <= 1'b0;
      iss_q   <= '0;
    end else if (upd) begin
      ex_en_q <= ex_en_d;
      iss_q   <= iss_d;
    end
  end

  assign oEX_En  = ex_en_q;
  assign oEX_Op  = iss_q.op;
  assign oEX_Pc  = iss_q.pc;
  assign oEX_Imm = iss_q.imm;
  assign oEX_Vs1 = iss_q.vs1;
  assign oEX_Vs2 = iss_q.vs2;
  assign oEX_Qd  = iss_q.qd;
endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: an entry-table model predicts every output after each
// edge, and literal checks at key points pin the model to hand-derived values.

module tb_rs_alu;
  localparam int N = 8, OPW = 5, DW = 32, TW = 4;

  logic           clk = 1'b0;
  logic           rst, en, iROB_Clear, iDP_En;
  logic [OPW-1:0] iDP_Op;
  logic [DW-1:0]  iDP_Pc, iDP_Imm, iDP_Vs1, iDP_Vs2;
  logic           iDP_Rdy1, iDP_Rdy2;
  logic [TW-1:0]  iDP_Qs1, iDP_Qs2, iDP_Qd;
  logic           oDP_Full;
  logic           iEX_En, iLSB_En;
  logic [TW-1:0]  iEX_Qd, iLSB_Qd;
  logic [DW-1:0]  iEX_Vd, iLSB_Vd;
  logic           oEX_En;
  logic [OPW-1:0] oEX_Op;
  logic [DW-1:0]  oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2;
  logic [TW-1:0]  oEX_Qd;

  rs_alu dut (
    .clk(clk), .rst(rst), .en(en), .iROB_Clear(iROB_Clear),
    .iDP_En(iDP_En), .iDP_Op(iDP_Op), .iDP_Pc(iDP_Pc), .iDP_Imm(iDP_Imm),
    .iDP_Rdy1(iDP_Rdy1), .iDP_Vs1(iDP_Vs1), .iDP_Qs1(iDP_Qs1),
    .iDP_Rdy2(iDP_Rdy2), .iDP_Vs2(iDP_Vs2), .iDP_Qs2(iDP_Qs2),
    .iDP_Qd(iDP_Qd), .oDP_Full(oDP_Full),
    .iEX_En(iEX_En), .iEX_Qd(iEX_Qd), .iEX_Vd(iEX_Vd),
    .iLSB_En(iLSB_En), .iLSB_Qd(iLSB_Qd), .iLSB_Vd(iLSB_Vd),
    .oEX_En(oEX_En), .oEX_Op(oEX_Op), .oEX_Pc(oEX_Pc), .oEX_Imm(oEX_Imm),
    .oEX_Vs1(oEX_Vs1), .oEX_Vs2(oEX_Vs2), .oEX_Qd(oEX_Qd)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit          busy;
    bit [4:0]    op;
    bit [31:0]   pc, imm, vs1, vs2;
    bit          r1, r2;
    bit [3:0]    q1, q2, qd;
  } ent_t;

  ent_t      m[N];
  bit        m_en;
  bit [4:0]  m_op;
  bit [31:0] m_pc, m_imm, m_vs1, m_vs2;
  bit [3:0]  m_qd;

  function automatic bit [32:0] grab(bit rdy, bit [31:0] v, bit [3:0] q);
    if (rdy) return {1'b1, v};
    if (iEX_En && iEX_Qd == q) return {1'b1, iEX_Vd};
    if (iLSB_En && iLSB_Qd == q) return {1'b1, iLSB_Vd};
    return {1'b0, v};
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    ent_t nx[N];
    int sel = -1, fr = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) m[i] = '{default: 0};
      m_en = 0; m_op = 0; m_pc = 0; m_imm = 0; m_vs1 = 0; m_vs2 = 0; m_qd = 0;
      return;
    end
    if (iROB_Clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_en = 0;
      return;
    end
    if (!en) return;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    nx = m;
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      {nx[i].r1, nx[i].vs1} = grab(m[i].r1, m[i].vs1, m[i].q1);
      {nx[i].r2, nx[i].vs2} = grab(m[i].r2, m[i].vs2, m[i].q2);
    end
    m_en = (sel >= 0);
    if (sel >= 0) begin
      m_op = m[sel].op; m_pc = m[sel].pc; m_imm = m[sel].imm;
      m_vs1 = m[sel].vs1; m_vs2 = m[sel].vs2; m_qd = m[sel].qd;
      nx[sel].busy = 0;
    end
    if (iDP_En && fr >= 0) begin
      nx[fr].busy = 1; nx[fr].op = iDP_Op; nx[fr].pc = iDP_Pc; nx[fr].imm = iDP_Imm;
      nx[fr].q1 = iDP_Qs1; nx[fr].q2 = iDP_Qs2; nx[fr].qd = iDP_Qd;
      {nx[fr].r1, nx[fr].vs1} = grab(iDP_Rdy1, iDP_Vs1, iDP_Qs1);
      {nx[fr].r2, nx[fr].vs2} = grab(iDP_Rdy2, iDP_Vs2, iDP_Qs2);
    end
    m = nx;
  endtask

  always @(posedge clk) begin
    model_edge();
    #1;
    chk("ex_en",  oEX_En,  m_en);
    chk("ex_op",  oEX_Op,  m_op);
    chk("ex_pc",  oEX_Pc,  m_pc);
    chk("ex_imm", oEX_Imm, m_imm);
    chk("ex_vs1", oEX_Vs1, m_vs1);
    chk("ex_vs2", oEX_Vs2, m_vs2);
    chk("ex_qd",  oEX_Qd,  m_qd);
    chk("full",   oDP_Full, m_full());
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    iDP_En = 0; iEX_En = 0; iLSB_En = 0; iROB_Clear = 0;
  endtask

  task automatic disp(input bit [4:0] op, input bit [31:0] imm,
                      input bit r1, input bit [31:0] v1, input bit [3:0] q1,
                      input bit r2, input bit [31:0] v2, input bit [3:0] q2,
                      input bit [3:0] qd);
    iDP_En = 1; iDP_Op = op; iDP_Imm = imm; iDP_Pc = 32'h100 + 32'(qd);
    iDP_Rdy1 = r1; iDP_Vs1 = v1; iDP_Qs1 = q1;
    iDP_Rdy2 = r2; iDP_Vs2 = v2; iDP_Qs2 = q2; iDP_Qd = qd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; en = 1; idle();
    iDP_Op = 0; iDP_Pc = 0; iDP_Imm = 0; iDP_Rdy1 = 0; iDP_Vs1 = 0; iDP_Qs1 = 0;
    iDP_Rdy2 = 0; iDP_Vs2 = 0; iDP_Qs2 = 0; iDP_Qd = 0;
    iEX_Qd = 0; iEX_Vd = 0; iLSB_Qd = 0; iLSB_Vd = 0;
    #2;
    chk("rst_en", oEX_En, 0);
    chk("rst_full", oDP_Full, 0);
    step(); rst = 0;

    // ready ADDI issues one edge after dispatch
    disp(5'b01011, 3, 1, 5, 0, 1, 0, 0, 2); step(); idle();
    chk("t1_lat", oEX_En, 0);
    step();
    chk("t1_en", oEX_En, 1); chk("t1_op", oEX_Op, 5'b01011);
    chk("t1_vs1", oEX_Vs1, 5); chk("t1_imm", oEX_Imm, 3); chk("t1_qd", oEX_Qd, 2);
    step();
    chk("t1_off", oEX_En, 0);

    // EX wakeup two cycles after dispatch
    disp(5'b00000, 0, 0, 0, 7, 1, 10, 0, 3); step(); idle(); step();
    iEX_En = 1; iEX_Qd = 7; iEX_Vd = 32'h20; step(); idle();
    chk("t2_wait", oEX_En, 0);
    step();
    chk("t2_en", oEX_En, 1); chk("t2_vs1", oEX_Vs1, 32'h20);
    chk("t2_vs2", oEX_Vs2, 10); chk("t2_qd", oEX_Qd, 3);
    step();

    // same-cycle LSB bypass at dispatch
    disp(5'b00001, 0, 1, 1, 0, 0, 0, 4, 5);
    iLSB_En = 1; iLSB_Qd = 4; iLSB_Vd = 32'hDEAD; step(); idle(); step();
    chk("t3_en", oEX_En, 1); chk("t3_vs2", oEX_Vs2, 32'hDEAD); chk("t3_qd", oEX_Qd, 5);
    step();

    // EX beats LSB on a tag collision
    disp(5'd2, 0, 0, 0, 6, 1, 0, 0, 6);
    iEX_En = 1; iEX_Qd = 6; iEX_Vd = 32'h11;
    iLSB_En = 1; iLSB_Qd = 6; iLSB_Vd = 32'h22; step(); idle(); step();
    chk("t3_prio", oEX_Vs1, 32'h11);
    step();

    // fill, overflow, wake 3 and 5 together
    for (int i = 0; i < N; i++) begin
      disp(5'd3, 0, 0, 0, 4'(8 + i), 1, 32'(i), 0, 4'(i)); step();
    end
    idle();
    chk("t4_full", oDP_Full, 1);
    disp(5'd4, 0, 1, 1, 0, 1, 1, 0, 15); step(); idle();
    chk("t4_ninth_full", oDP_Full, 1); chk("t4_ninth_en", oEX_En, 0);
    iEX_En = 1; iEX_Qd = 11; iEX_Vd = 32'h33;
    iLSB_En = 1; iLSB_Qd = 13; iLSB_Vd = 32'h55; step(); idle();
    chk("t4_full_iss", oDP_Full, 1);
    step();
    chk("t4_e3", oEX_En, 1); chk("t4_q3", oEX_Qd, 3); chk("t4_v3", oEX_Vs1, 32'h33);
    step();
    chk("t4_e5", oEX_En, 1); chk("t4_q5", oEX_Qd, 5); chk("t4_v5", oEX_Vs1, 32'h55);
    step();
    chk("t4_done", oEX_En, 0);

    // flush with four busy and a dispatch in the same cycle
    iROB_Clear = 1; step(); idle();
    chk("t5_pre_full", oDP_Full, 0);
    for (int i = 0; i < 4; i++) begin
      disp(5'd6, 0, 0, 0, 9, 1, 0, 0, 4'(i)); step();
    end
    idle();
    iROB_Clear = 1; disp(5'd7, 0, 1, 1, 0, 1, 1, 0, 12); step(); idle();
    chk("t5_en", oEX_En, 0); chk("t5_full", oDP_Full, 0);
    step();
    chk("t5_drop", oEX_En, 0);
    iEX_En = 1; iEX_Qd = 9; iEX_Vd = 32'h1; step(); idle(); step();
    chk("t5_stale", oEX_En, 0);

    // async reset while issuing, then en freeze
    disp(5'd8, 0, 1, 32'h77, 0, 1, 32'h88, 0, 1); step(); idle(); step();
    chk("t6_pre", oEX_En, 1);
    rst = 1; #1;
    chk("t6_async_en", oEX_En, 0); chk("t6_async_vs1", oEX_Vs1, 0);
    step(); rst = 0;
    disp(5'd9, 0, 1, 32'h5, 0, 1, 32'h6, 0, 2); step(); idle();
    en = 0; step(); step();
    chk("t6_hold", oEX_En, 0);
    en = 1; step();
    chk("t6_go", oEX_En, 1); chk("t6_go_qd", oEX_Qd, 2);
    en = 0; step();
    chk("t6_freeze", oEX_En, 1);
    en = 1; step();
    chk("t6_end", oEX_En, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
